// File: rtl/ej32_xalu.sv
// eJ32 extended ALU: combinational signed multiply and barrel shifts, plus a
// restoring signed divider that restarts every time rst is released.
module ej32_xalu #(
    parameter int DSZ = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DSZ-1:0]       s,
    input  logic [DSZ-1:0]       t,
    input  logic                 shr_f,
    output logic [2*DSZ-1:0]     mul_v,
    output logic [DSZ-1:0]       sht_v,
    output logic [DSZ-1:0]       ushr_v,
    output logic                 div_bsy,
    output logic                 div_z,
    output logic [DSZ-1:0]       div_q,
    output logic [DSZ-1:0]       div_r
);
    localparam int SW = $clog2(DSZ);

    typedef enum logic [1:0] {LOAD, ITER, FIX, DONE} state_t;

    state_t                r_st;
    logic [DSZ-1:0]        r_quo;
    logic [DSZ-1:0]        r_rem;
    logic [DSZ-1:0]        r_dvs;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_bsy;
    logic                  r_z;
    logic [SW-1:0]         r_cnt;

    logic [SW-1:0]         w_sha;
    logic signed [2*DSZ-1:0] w_s_ext;
    logic signed [2*DSZ-1:0] w_t_ext;
    logic [DSZ-1:0]        w_shl;
    logic signed [DSZ-1:0] w_sra;
    logic [DSZ-1:0]        w_srl;
    logic [DSZ-1:0]        w_abs_s;
    logic [DSZ-1:0]        w_abs_t;
    logic [DSZ-1:0]        w_rem_sh;
    logic [DSZ:0]          w_diff;

    // Full-width sign extension so the low 2*DSZ bits of the product are the signed product.
    assign w_s_ext = {{DSZ{s[DSZ-1]}}, s};
    assign w_t_ext = {{DSZ{t[DSZ-1]}}, t};
    assign mul_v   = w_s_ext * w_t_ext;

    // Arithmetic right shift kept in its own signed wire so the mux cannot demote it to logical.
    assign w_sha  = t[SW-1:0];
    assign w_shl  = s << w_sha;
    assign w_sra  = $signed(s) >>> w_sha;
    assign w_srl  = s >> w_sha;
    assign sht_v  = shr_f ? w_sra : w_shl;
    assign ushr_v = w_srl;

    assign w_abs_s  = s[DSZ-1] ? -s : s;
    assign w_abs_t  = t[DSZ-1] ? -t : t;
    assign w_rem_sh = {r_rem[DSZ-2:0], r_quo[DSZ-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {1'b0, r_dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st    <= LOAD;
            r_bsy   <= 1'b1;
            r_z     <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_st)
                LOAD: begin
                    if (t == '0) begin
                        r_z   <= 1'b1;
                        r_quo <= '0;
                        r_rem <= s;
                        r_bsy <= 1'b0;
                        r_st  <= DONE;
                    end else begin
                        r_rem   <= '0;
                        r_quo   <= w_abs_s;
                        r_dvs   <= w_abs_t;
                        r_neg_r <= s[DSZ-1];
                        r_neg_q <= s[DSZ-1] ^ t[DSZ-1];
                        r_st    <= ITER;
                    end
                end
                ITER: begin
                    // Quotient bits shift in from the bottom while the dividend shifts out the top.
                    r_cnt <= r_cnt + SW'(1);
                    r_quo <= {r_quo[DSZ-2:0], ~w_diff[DSZ]};
                    r_rem <= w_diff[DSZ] ? w_rem_sh : w_diff[DSZ-1:0];
                    if (r_cnt == '1)
                        r_st <= FIX;
                end
                FIX: begin
                    if (r_neg_q)
                        r_quo <= -r_quo;
                    if (r_neg_r)
                        r_rem <= -r_rem;
                    r_bsy <= 1'b0;
                    r_st  <= DONE;
                end
                default: ;
            endcase
        end
    end

    assign div_bsy = r_bsy;
    assign div_z   = r_z;
    assign div_q   = r_quo;
    assign div_r   = r_rem;
endmodule

// File: tb/tb_ej32_xalu.sv
// Bench for ej32_xalu: divider results go through a scoreboard queue checked by a
// monitor on div_bsy falling; multiply and shift outputs are compared directly.
module tb_ej32_xalu;
    logic        clk;
    logic        rst;
    logic [31:0] s;
    logic [31:0] t;
    logic        shr_f;
    logic [63:0] mul_v;
    logic [31:0] sht_v;
    logic [31:0] ushr_v;
    logic        div_bsy;
    logic        div_z;
    logic [31:0] div_q;
    logic [31:0] div_r;

    ej32_xalu #(.DSZ(32)) dut (
        .clk(clk), .rst(rst), .s(s), .t(t), .shr_f(shr_f),
        .mul_v(mul_v), .sht_v(sht_v), .ushr_v(ushr_v),
        .div_bsy(div_bsy), .div_z(div_z), .div_q(div_q), .div_r(div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: counts edges since rst release and checks the result when div_bsy drops.
    int  mon_cnt = 0;
    bit  armed   = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            armed   = 1;
            mon_cnt = 0;
        end else begin
            mon_cnt++;
            if (armed && !div_bsy) begin
                armed = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=q%h/r%h expected=none", div_q, div_r);
                end else begin
                    e = sb.pop_front();
                    chk("div_q",   {32'd0, div_q}, {32'd0, e.q});
                    chk("div_r",   {32'd0, div_r}, {32'd0, e.r});
                    chk("div_z",   {63'd0, div_z}, {63'd0, e.z});
                    chk("div_lat", 64'(mon_cnt),   64'(e.lat));
                end
                n_done++;
            end
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic ez, input int lat);
        exp_t e;
        int   d0;
        int   k;
        @(negedge clk);
        rst = 1'b1;
        s   = a;
        t   = b;
        e.q = eq; e.r = er; e.z = ez; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        d0  = n_done;
        k   = 0;
        while (n_done == d0 && k < 60) begin
            @(negedge clk);
            k++;
            // Operands are latched at LOAD; scribble over them mid-divide.
            if (k == 3) begin
                s = $urandom;
                t = $urandom;
            end
        end
        if (n_done == d0) begin
            checks++;
            errors++;
            $display("FAIL div_timeout actual=busy expected=done a=%h b=%h", a, b);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            s = ~s;
            t = $urandom;
            repeat (2) @(negedge clk);
            chk("hold_q", {32'd0, div_q}, {32'd0, eq});
            chk("hold_r", {32'd0, div_r}, {32'd0, er});
            chk("hold_bsy", {63'd0, div_bsy}, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst   = 1'b1;
        s     = 32'd0;
        t     = 32'd0;
        shr_f = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bsy", {63'd0, div_bsy}, 64'd1);
        chk("rst_z",   {63'd0, div_z},   64'd0);
        chk("rst_q",   {32'd0, div_q},   64'd0);
        chk("rst_r",   {32'd0, div_r},   64'd0);

        run_div(32'd7,          32'hFFFFFFFD, 32'hFFFFFFFE, 32'd1,        1'b0, 34);
        run_div(32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
        run_div(32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34);
        run_div(32'd5,          32'd0,        32'd0,        32'd5,        1'b1, 1);
        run_div(32'hFFFFFFFF,   32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 1);
        run_div(32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34);
        run_div(32'h80000000,   32'd1,        32'h80000000, 32'd0,        1'b0, 34);
        run_div(32'h7FFFFFFF,   32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 34);

        // Abort a 100/7 divide mid-flight; the async reset must clear outputs at once.
        @(negedge clk);
        rst = 1'b1;
        s   = 32'd100;
        t   = 32'd7;
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_bsy", {63'd0, div_bsy}, 64'd1);
        chk("abort_q",   {32'd0, div_q},   64'd0);
        chk("abort_r",   {32'd0, div_r},   64'd0);
        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

        s = 32'hFFFFFFFE; t = 32'd3; #1;
        chk("mul_neg", mul_v, 64'hFFFFFFFF_FFFFFFFA);
        s = 32'h00010000; t = 32'h00010000; #1;
        chk("mul_big", mul_v, 64'h00000001_00000000);
        s = 32'h80000000; t = 32'h80000000; #1;
        chk("mul_min", mul_v, 64'h40000000_00000000);

        s = 32'h80000001; t = 32'h00000021; shr_f = 1'b0; #1;
        chk("ishl_1",  {32'd0, sht_v},  64'h00000002);
        chk("iushr_1", {32'd0, ushr_v}, 64'h40000000);
        shr_f = 1'b1; #1;
        chk("ishr_1",  {32'd0, sht_v},  64'hC0000000);
        t = 32'hFFFFFFE0; #1;
        chk("ishr_0",  {32'd0, sht_v},  64'h80000001);
        chk("iushr_0", {32'd0, ushr_v}, 64'h80000001);
        t = 32'd31; #1;
        chk("ishr_31",  {32'd0, sht_v},  64'hFFFFFFFF);
        chk("iushr_31", {32'd0, ushr_v}, 64'h00000001);
        shr_f = 1'b0; #1;
        chk("ishl_31", {32'd0, sht_v}, 64'h80000000);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
            if (rb == 32'd0) rb = 32'd3;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
            s = ra; t = rb; #1;
            chk("mul_rnd", mul_v, 64'(longint'($signed(ra)) * longint'($signed(rb))));
            run_div(ra, rb, 32'($signed(ra) / $signed(rb)), 32'($signed(ra) % $signed(rb)), 1'b0, 34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
